// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the bubble encoding, the default reset PC and the fetch FSM states.
package fetch_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch stage is the master; the memory is the slave.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID output register: load a new instruction, hold it, or flush to a bubble.
// A flush keeps NPC so the bubble still carries the last known sequential address.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] ir_in,
  input  logic [31:0] npc_in,
  output logic [31:0] ir_o,
  output logic [31:0] npc_o,
  output logic        valid_o
);

  logic [31:0] ir_d, ir_q;
  logic [31:0] npc_d, npc_q;
  logic        valid_d, valid_q;

  // Next register contents: flush wins over load, otherwise hold.
  always_comb begin
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = NOP;
      valid_d = 1'b0;
    end else if (load) begin
      ir_d    = ir_in;
      npc_d   = npc_in;
      valid_d = 1'b1;
    end
  end

  // Register state with asynchronous reset to an empty bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q    <= NOP;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign ir_o    = ir_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: pc, one-entry stall buffer and request FSM.
// Bus outputs come only from registers; rdata/stall reach outputs via flops.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] NPC_if,
  output logic [31:0] IR_if,
  output logic        valid_if
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  buf_ir_d, buf_ir_q;
  logic [31:0]  buf_npc_d, buf_npc_q;
  logic [31:0]  drop_addr_d, drop_addr_q;
  logic         req_en_d, req_en_q;

  logic         ack;
  logic         load, flush;
  logic [31:0]  ld_ir, ld_npc;
  logic [31:0]  pc_inc, redir_pc;

  assign pc_inc   = pc_q + 32'd4;
  assign redir_pc = redirect_pc & ~32'h3;

  // Bus drive: no request in HOLD or in the first cycle after reset.
  always_comb begin
    imem.imem_req  = req_en_q && (state_q != S_HOLD);
    imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  end

  // An ack only counts against a request we actually issued.
  assign ack = imem.imem_ack && imem.imem_req;

  // Next-state, pc, buffer and IF/ID control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_ir_d    = buf_ir_q;
    buf_npc_d   = buf_npc_q;
    drop_addr_d = drop_addr_q;
    req_en_d    = 1'b1;
    load        = 1'b0;
    flush       = 1'b0;
    ld_ir       = imem.imem_rdata;
    ld_npc      = pc_inc;
    if (redirect) begin
      pc_d  = redir_pc;
      flush = 1'b1;
      unique case (state_q)
        S_FETCH: begin
          if (imem.imem_req && !ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_DROP:  state_d = ack ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (stall) begin
              buf_ir_d  = imem.imem_rdata;
              buf_npc_d = pc_inc;
              state_d   = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end else if (!stall) begin
            flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load    = 1'b1;
            ld_ir   = buf_ir_q;
            ld_npc  = buf_npc_q;
            state_d = S_FETCH;
          end
        end
        default: begin
          if (ack) state_d = S_FETCH;
          if (!stall) flush = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      buf_ir_q    <= NOP;
      buf_npc_q   <= 32'h0000_0000;
      drop_addr_q <= 32'h0000_0000;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_ir_q    <= buf_ir_d;
      buf_npc_q   <= buf_npc_d;
      drop_addr_q <= drop_addr_d;
      req_en_q    <= req_en_d;
    end
  end

  if_id_reg #(.NOP(NOP)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (flush),
    .ir_in   (ld_ir),
    .npc_in  (ld_npc),
    .ir_o    (IR_if),
    .npc_o   (NPC_if),
    .valid_o (valid_if)
  );

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 Parameter NOP, default 32'h0000_0000, bubble encoding driven on IR_if when no valid instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory request; held high until imem_ack.
REQ-006 imem_addr  output  32  word address of outstanding request; stable while imem_req high.
REQ-007 imem_ack  input  1  memory has returned imem_rdata this cycle; may arrive same cycle as request or any later cycle.
REQ-008 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-009 stall  input  1  downstream (decode) cannot accept; IF/ID outputs must hold.
REQ-010 redirect  input  1  taken branch/jump from execute; flushes fetch.
REQ-011 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-012 NPC_if  output  32  registered address of the instruction after IR_if (PC+4).
REQ-013 IR_if  output  32  registered fetched instruction.
REQ-014 valid_if  output  1  IR_if/NPC_if hold a real instruction.

Function
REQ-015 States: FETCH (request active), HOLD (word buffered, waiting on stall), DROP (stale request in flight after redirect).
REQ-016 pc register holds next fetch address; PC+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); redirect_pc[1:0] forced to 2'b00.
REQ-017 FETCH: imem_req=1, imem_addr=pc; HOLD: imem_req=0; DROP: imem_req=1, imem_addr=address of stale request.
REQ-018 FETCH, ack, no redirect, no stall: next edge IR_if<=imem_rdata, NPC_if<=pc+4, valid_if<=1, pc<=pc+4; stay FETCH; zero-bubble throughput of one instruction per acked cycle.
REQ-019 FETCH, ack, stall, no redirect: word and pc+4 captured into one-entry buffer, pc<=pc+4, outputs unchanged, go HOLD.
REQ-020 FETCH, no ack, no redirect: outputs unchanged if stall, else valid_if<=0 and IR_if<=NOP.
REQ-021 HOLD, stall deasserted, no redirect: buffer moves to IR_if/NPC_if with valid_if=1, go FETCH.
REQ-022 Redirect has priority over stall and ack in every state: next edge pc<=redirect_pc, valid_if<=0, IR_if<=NOP, NPC_if unchanged; any buffered or acked word is discarded.
REQ-023 Redirect in FETCH with ack same cycle: go FETCH (request for redirect_pc begins next cycle).
REQ-024 Redirect in FETCH without ack: go DROP; in DROP the returning ack's data is discarded, then go FETCH.
REQ-025 Redirect in DROP: pc<=redirect_pc (latest wins), stay DROP.
REQ-026 Redirect in HOLD: buffer discarded, go FETCH.
REQ-027 While stall=1 and no redirect, IR_if, NPC_if, valid_if are held bit-for-bit.
REQ-028 No combinational path from imem_rdata or stall to any output; imem_req/imem_addr depend only on state registers.

Reset
REQ-029 On rst assertion, without waiting for clk: pc=RESET_PC, state=FETCH, IR_if=NOP, NPC_if=0, valid_if=0, buffer empty, imem_req=0.
REQ-030 imem_req first asserted, with imem_addr=RESET_PC, in the cycle after rst deasserts; a reset mid-request abandons it (no DROP).

Structure
REQ-031 Shared pipeline package holds NOP encoding, RESET_PC default, and the fetch-state enumeration.
REQ-032 One sub-module, if_id_reg, implements the IF/ID output register with load, hold and flush controls; fetch contains pc, buffer and FSM.

Verification
REQ-033 Reset release, ack every cycle, no stall: imem_addr 0,4,8,...; IR_if matches memory, NPC_if 4,8,12 from cycle 2, valid_if=1 continuously.
REQ-034 Stall for 3 cycles while ack on address 0x10: outputs frozen, imem_req low in HOLD; after release IR_if=mem[0x10], NPC_if=0x14, next request 0x14.
REQ-035 Ack latency 3 cycles, redirect to 0x1000 one cycle after request to 0x20: data for 0x20 never reaches IR_if; next request 0x1000; valid_if=0 until its ack.
REQ-036 Redirect and stall asserted together in HOLD: next cycle valid_if=0, IR_if=NOP, buffer dropped, request 0x1000.
REQ-037 pc=0xFFFF_FFFC acked: NPC_if=0x0000_0000, next imem_addr=0x0000_0000; redirect_pc=0x203 fetches 0x200.
REQ-038 rst asserted mid-wait and mid-HOLD: outputs reset asynchronously; first post-reset request at RESET_PC, stale ack ignored.
